// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute sequencer with a program-memory handshake and control ROM.
// Defining INSTR_SEQUENCER_SINGLE_STEP_EN adds a step input; each step rising edge runs one instruction.
module instr_sequencer #(
  parameter logic [3:0]  RESET_PC       = 4'h0,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  input  logic       step,
`endif
  output logic       pm_req,
  output logic [3:0] pm_addr,
  input  logic       pm_ack,
  input  logic [7:0] pm_data,
  output logic [3:0] rom_addr,
  input  logic [9:0] rom_prog,
  input  logic       carry_in,
  output logic [9:0] ctrl,
  output logic       ctrl_valid,
  output logic [3:0] imm,
  output logic [3:0] pc,
  output logic       halted,
  output logic       fault
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, HALT, FAULT} state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [3:0] imm_q, imm_d;
  logic [3:0] rom_addr_q, rom_addr_d;
  logic [9:0] ctrl_q, ctrl_d;
  logic       ctrl_valid_q, ctrl_valid_d;
  logic       pm_req_q, pm_req_d;
  logic       halted_q, halted_d;
  logic       fault_q, fault_d;
  logic [7:0] tmo_q, tmo_d;
  logic       start_ok;
  logic       exec_continue;

`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  logic step_q;
  // Stepping always parks in IDLE after EXECUTE, so only IDLE looks at the step edge.
  assign start_ok      = run & step & ~step_q;
  assign exec_continue = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step;
  end
`else
  assign start_ok      = run;
  assign exec_continue = run;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    imm_d        = imm_q;
    rom_addr_d   = rom_addr_q;
    ctrl_d       = ctrl_q;
    ctrl_valid_d = 1'b0;
    pm_req_d     = pm_req_q;
    halted_d     = halted_q;
    fault_d      = fault_q;
    tmo_d        = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d  = FETCH;
          pm_req_d = 1'b1;
          tmo_d    = '0;
        end
      end
      FETCH: begin
        // An ack in the last allowed cycle still wins over the timeout.
        if (pm_ack && pm_req_q) begin
          rom_addr_d = pm_data[7:4];
          imm_d      = pm_data[3:0];
          pc_d       = pc_q + 4'd1;
          pm_req_d   = 1'b0;
          state_d    = DECODE;
        end else if (tmo_q == TMO_LAST) begin
          pm_req_d = 1'b0;
          fault_d  = 1'b1;
          state_d  = FAULT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      DECODE: begin
        if (rom_addr_q == 4'hA || rom_addr_q == 4'hB) begin
          halted_d = 1'b1;
          state_d  = HALT;
        end else begin
          ctrl_d       = rom_prog;
          ctrl_valid_d = 1'b1;
          state_d      = EXECUTE;
        end
      end
      EXECUTE: begin
        if (rom_addr_q == 4'hF || (rom_addr_q == 4'hE && !carry_in)) pc_d = imm_q;
        if (exec_continue) begin
          state_d  = FETCH;
          pm_req_d = 1'b1;
          tmo_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      HALT:    state_d = HALT;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      imm_q        <= '0;
      rom_addr_q   <= '0;
      ctrl_q       <= '0;
      ctrl_valid_q <= 1'b0;
      pm_req_q     <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      imm_q        <= imm_d;
      rom_addr_q   <= rom_addr_d;
      ctrl_q       <= ctrl_d;
      ctrl_valid_q <= ctrl_valid_d;
      pm_req_q     <= pm_req_d;
      halted_q     <= halted_d;
      fault_q      <= fault_d;
      tmo_q        <= tmo_d;
    end
  end

  assign pm_req     = pm_req_q;
  assign pm_addr    = pc_q;
  assign rom_addr   = rom_addr_q;
  assign ctrl       = ctrl_q;
  assign ctrl_valid = ctrl_valid_q;
  assign imm        = imm_q;
  assign pc         = pc_q;
  assign halted     = halted_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a responder serves fetches from a program array and
// predicts control words and next-pc; a monitor checks every ctrl_valid against the queue.
module tb_instr_sequencer;
  localparam logic [3:0] RST_PC = 4'h0;
  localparam int         TMO    = 15;

  logic       clk = 1'b0, rst_n = 1'b0, run = 1'b0;
  logic       pm_req, pm_ack = 1'b0, carry_in = 1'b0;
  logic [3:0] pm_addr, rom_addr, imm, pc;
  logic [7:0] pm_data = 8'h00;
  logic [9:0] rom_prog, ctrl;
  logic       ctrl_valid, halted, fault;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  logic       step = 1'b0;
`endif

  instr_sequencer #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
    .step(step),
`endif
    .pm_req(pm_req), .pm_addr(pm_addr), .pm_ack(pm_ack), .pm_data(pm_data),
    .rom_addr(rom_addr), .rom_prog(rom_prog), .carry_in(carry_in),
    .ctrl(ctrl), .ctrl_valid(ctrl_valid), .imm(imm), .pc(pc),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [9:0] ctrl; int ack_cyc; } exp_t;
  exp_t sb[$];

  logic [7:0] mem [16];
  logic [9:0] rom [16];
  assign rom_prog = rom[rom_addr];

  int vectors = 0, miscompares = 0;
  int n_valid = 0, prev_valid_cyc = -100, last_valid_cyc = -100;
  int model_pc = 0;
  bit resp_en = 1'b1;
  bit stray = 1'b0;
  int fixed_wait = 0;   // -1 selects a random wait per fetch
  int max_wait = 4;
  int carry_mode = -1;  // -1 selects a random carry per instruction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Responder plus reference model: serves each fetch, predicts ctrl word and next pc.
  initial begin
    int wcnt, wtarget;
    logic [7:0] ins;
    logic [3:0] op, im;
    logic       cy;
    wcnt = 0; wtarget = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pm_ack  = 1'b0;
        wcnt    = 0;
        wtarget = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, max_wait));
      end else if (pm_ack) begin
        pm_ack = 1'b0;
      end else if (stray) begin
        pm_data = 8'hF5;
        pm_ack  = 1'b1;
      end else if (pm_req && resp_en) begin
        if (wcnt >= wtarget) begin
          chk("fetch_addr", {28'd0, pm_addr}, model_pc);
          ins = mem[model_pc];
          op  = ins[7:4];
          im  = ins[3:0];
          cy  = (carry_mode < 0) ? 1'($urandom_range(0, 1)) : 1'(carry_mode);
          carry_in = cy;
          pm_data  = ins;
          pm_ack   = 1'b1;
          if (op != 4'hA && op != 4'hB) begin
            sb.push_back('{rom[op], cyc});
            if (op == 4'hF || (op == 4'hE && !cy)) model_pc = int'(im);
            else model_pc = (model_pc + 1) % 16;
          end else begin
            model_pc = (model_pc + 1) % 16;
          end
          wcnt    = 0;
          wtarget = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, max_wait));
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Monitor: every ctrl_valid pops one prediction and checks word and latency.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ctrl_valid) begin
        n_valid++;
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ctrl_valid: got ctrl 0x%0h expected no pulse (t=%0t)", ctrl, $time);
        end else begin
          e = sb.pop_front();
          chk("ctrl", {22'd0, ctrl}, {22'd0, e.ctrl});
          chk("latency", cyc, e.ack_cyc + 2);
        end
      end
    end
  end

  task automatic do_reset(input bit full);
    rst_n = 1'b0;
    sb.delete();
    model_pc = int'(RST_PC);
    repeat (3) @(negedge clk);
    chk("rst_pc", {28'd0, pc}, {28'd0, RST_PC});
    chk("rst_pm_req", {31'd0, pm_req}, 0);
    chk("rst_halted", {31'd0, halted}, 0);
    chk("rst_fault", {31'd0, fault}, 0);
    if (full) begin
      chk("rst_ctrl", {22'd0, ctrl}, 0);
      chk("rst_ctrl_valid", {31'd0, ctrl_valid}, 0);
      chk("rst_imm", {28'd0, imm}, 0);
      chk("rst_rom_addr", {28'd0, rom_addr}, 0);
      chk("rst_pm_addr", {28'd0, pm_addr}, {28'd0, RST_PC});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_valid(input int target, input int budget, input string nm);
    int b = 0;
    while (n_valid < target && b < budget) begin
      @(negedge clk);
      b++;
    end
    if (n_valid < target) chk(nm, n_valid, target);
  endtask

  task automatic wait_pm_req(input int budget);
    int b = 0;
    while (!pm_req && b < budget) begin
      @(negedge clk);
      b++;
    end
    if (!pm_req) chk("pm_req_timeout", {31'd0, pm_req}, 1);
  endtask

  task automatic settle(input string nm);
    int hi = 0;
    repeat (12) @(negedge clk);
    repeat (8) begin
      @(negedge clk);
      if (pm_req) hi++;
    end
    chk({nm, "_idle_pm_req"}, hi, 0);
    chk({nm, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    int base, n;
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      rom[i] = 10'($urandom);
      mem[i] = 8'h00;
    end

    do_reset(1'b1);

    // Two-instruction program with zero-wait acks.
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h50;
    fixed_wait = 0; carry_mode = 0;
    do_reset(1'b0);
    base = n_valid;
    run = 1'b1;
    wait_valid(base + 2, 30, "prog2_timeout");
    chk("valid_spacing", last_valid_cyc - prev_valid_cyc, 3);
    chk("pc_after_two", {28'd0, pc}, 2);
    run = 1'b0;
    settle("prog2");

    // pc wrap from 15 to 0.
    mem[0] = 8'hF7; mem[7] = 8'hFF; mem[15] = 8'h20;
    do_reset(1'b0);
    base = n_valid;
    run = 1'b1;
    wait_valid(base + 3, 40, "wrap_timeout");
    chk("pc_wrap", {28'd0, pc}, 0);
    run = 1'b0;
    settle("wrap");

    // Conditional jump taken, then unconditional jump.
    mem[0] = 8'hE5; mem[1] = 8'h11; mem[2] = 8'h33; mem[5] = 8'hF9; mem[9] = 8'h22;
    carry_mode = 0;
    do_reset(1'b0);
    base = n_valid;
    run = 1'b1;
    wait_valid(base + 3, 40, "jmp_taken_timeout");
    chk("pc_jmp_taken", {28'd0, pc}, 10);
    run = 1'b0;
    settle("jmp_taken");

    // Conditional jump not taken.
    carry_mode = 1;
    do_reset(1'b0);
    base = n_valid;
    run = 1'b1;
    wait_valid(base + 2, 40, "jmp_not_taken_timeout");
    chk("pc_jmp_not_taken", {28'd0, pc}, 2);
    run = 1'b0;
    settle("jmp_not_taken");

    // run dropped while a fetch waits: the instruction still completes once.
    carry_mode = -1; fixed_wait = 5;
    do_reset(1'b0);
    run = 1'b1;
    wait_pm_req(10);
    @(negedge clk);
    run = 1'b0;
    base = n_valid;
    repeat (20) @(negedge clk);
    chk("run_drop_one_instr", n_valid - base, 1);
    settle("run_drop");

    // Reset mid-handshake drops pm_req at once; a stray ack in IDLE is ignored.
    resp_en = 1'b0; fixed_wait = 0;
    do_reset(1'b0);
    run = 1'b1;
    wait_pm_req(10);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_pm_req", {31'd0, pm_req}, 0);
    run = 1'b0;
    sb.delete();
    model_pc = int'(RST_PC);
    @(negedge clk);
    rst_n = 1'b1;
    resp_en = 1'b1;
    stray = 1'b1;
    repeat (2) @(negedge clk);
    stray = 1'b0;
    repeat (5) @(negedge clk);
    chk("stray_ack_pc", {28'd0, pc}, {28'd0, RST_PC});
    chk("stray_ack_pm_req", {31'd0, pm_req}, 0);
    mem[0] = 8'h12;
    base = n_valid;
    run = 1'b1;
    wait_valid(base + 1, 20, "post_stray_timeout");
    run = 1'b0;
    settle("stray");

    // Fetch timeout with the ack withheld entirely.
    resp_en = 1'b0;
    do_reset(1'b0);
    run = 1'b1;
    wait_pm_req(10);
    n = 0;
    while (pm_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_req_cycles", n, TMO);
    chk("timeout_fault", {31'd0, fault}, 1);
    chk("timeout_pm_req", {31'd0, pm_req}, 0);
    chk("timeout_halted", {31'd0, halted}, 0);
    run = 1'b0;
    settle("fault");

    // Ack in the last allowed cycle still decodes normally.
    resp_en = 1'b1; fixed_wait = TMO - 1;
    do_reset(1'b0);
    base = n_valid;
    run = 1'b1;
    wait_valid(base + 1, 40, "late_ack_timeout");
    chk("late_ack_no_fault", {31'd0, fault}, 0);
    run = 1'b0;
    settle("late_ack");

    // Halt opcode: no ctrl pulse, no further fetches, exit only by reset.
    fixed_wait = 0;
    mem[0] = 8'hA0;
    do_reset(1'b0);
    base = n_valid;
    run = 1'b1;
    n = 0;
    while (!halted && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("halt_halted", {31'd0, halted}, 1);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (pm_req) n++;
    end
    chk("halt_pm_req_cycles", n, 0);
    chk("halt_no_valid", n_valid - base, 0);
    chk("halt_no_fault", {31'd0, fault}, 0);
    run = 1'b0;
    do_reset(1'b0);

    // Randomized sessions: random program, waits, carry and run-drop point.
    fixed_wait = -1; carry_mode = -1;
    do_reset(1'b0);
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < 16; i++) begin
        b = 8'($urandom);
        if (b[7:4] == 4'hA) b[7:4] = 4'hE;
        if (b[7:4] == 4'hB) b[7:4] = 4'hF;
        mem[i] = b;
      end
      base = n_valid;
      run = 1'b1;
      wait_valid(base + int'($urandom_range(3, 12)), 400, "rand_timeout");
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run = 1'b0;
      settle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 4'h0: program counter value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 15 (range 1..255): maximum wait cycles for pm_ack before FAULT.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port run  input  1  level; enables instruction execution.
REQ-006 SHALL have port pm_req  output  1  program-memory read request.
REQ-007 SHALL have port pm_addr  output  4  program-memory address (current pc).
REQ-008 SHALL have port pm_ack  input  1  program-memory acknowledge; pm_data valid in same cycle.
REQ-009 SHALL have port pm_data  input  8  instruction; [7:4] opcode, [3:0] immediate.
REQ-010 SHALL have port rom_addr  output  4  control-ROM address (latched opcode).
REQ-011 SHALL have port rom_prog  input  10  combinational control word returned by ROM.
REQ-012 SHALL have port carry_in  input  1  ALU carry flag for conditional jump.
REQ-013 SHALL have ports ctrl (output, 10, registered control word), ctrl_valid (output, 1, ctrl qualifier), imm (output, 4, latched immediate), pc (output, 4), halted (output, 1), fault (output, 1).

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, DECODE, EXECUTE, HALT, FAULT.
REQ-015 IDLE: run=1 -> FETCH next cycle; run=0 -> stay.
REQ-016 FETCH: pm_req=1, pm_addr=pc held stable until pm_ack; on pm_ack latch opcode/imm, pc <= pc+1 mod 16 (15 wraps to 0), -> DECODE.
REQ-017 pm_ack while pm_req=0 SHALL be ignored.
REQ-018 FETCH timeout: TIMEOUT_CYCLES consecutive cycles with pm_req=1 and no pm_ack -> FAULT; counter cleared on entry to FETCH.
REQ-019 DECODE: rom_addr=latched opcode (one cycle); opcodes 4'hA and 4'hB -> HALT, others -> EXECUTE.
REQ-020 EXECUTE: ctrl <= rom_prog sampled at DECODE, ctrl_valid=1 for exactly one cycle; ctrl holds value until next EXECUTE, ctrl_valid=0 otherwise.
REQ-021 Opcode 4'hF SHALL load pc <= imm in EXECUTE; opcode 4'hE SHALL load pc <= imm only if carry_in=0 in EXECUTE; jump overrides the fetch increment.
REQ-022 End of EXECUTE: run=1 -> FETCH; run=0 -> IDLE; run SHALL be sampled only in IDLE and EXECUTE (deassertion mid-instruction completes the instruction).
REQ-023 Latency: pm_ack in cycle N -> ctrl_valid in cycle N+2; back-to-back zero-wait instructions every 3 cycles.
REQ-024 HALT: halted=1, pm_req=0, ctrl_valid=0; exit only via reset.
REQ-025 FAULT: fault=1, pm_req=0, ctrl_valid=0; exit only via reset.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, pc=RESET_PC, pm_req=0, ctrl=0, ctrl_valid=0, imm=0, rom_addr=0, halted=0, fault=0, timeout counter 0.
REQ-027 Reset asserted mid-handshake SHALL drop pm_req asynchronously; a later pm_ack SHALL be ignored.

Configuration
REQ-028 Macro INSTR_SEQUENCER_SINGLE_STEP_EN defined: SHALL add input step (1 bit); after EXECUTE, FSM waits in IDLE until step rising edge (run still required), one instruction per step edge.
REQ-029 Macro undefined: step port SHALL not exist; behaviour per REQ-022.

Verification
REQ-030 Reset, run=1, pm_ack immediate, program {0x12,0x34} -> pc 0->1->2, ctrl_valid pulses 3 cycles apart, ctrl equals ROM words for opcodes 1 and 3.
REQ-031 pc=15 fetch of 0x20 -> pc wraps to 0.
REQ-032 0xE5 with carry_in=0 -> pc=5; with carry_in=1 -> pc=next sequential; 0xF9 -> pc=9 regardless.
REQ-033 pm_ack withheld 15 cycles (default) -> fault=1, pm_req=0; ack at cycle 14 -> normal DECODE.
REQ-034 Fetch 0xA0 -> halted=1, no ctrl_valid, pm_req stays 0 for 20 cycles; rst_n pulse -> IDLE, pc=RESET_PC.
REQ-035 run dropped during FETCH wait, ack 3 cycles later -> instruction executes once, then IDLE, pm_req=0.
